iomem_bus_router: RTL and testbench
===================================

# iomem_bus_router

Parametrised N-channel router for the SoC's `iomem` bus, placed between the CPU-side `iomem_*` port and the peripherals that sit above the flash/config region. It decodes equal-sized address windows, forwards one transaction at a time to the selected slave, and registers the slave's response. It returns a fixed error word, with a sticky error flag and interrupt, for unmapped addresses and, optionally, for slaves that never respond.

## Interface
- `NUM_SLAVES`, default 4: number of slave channels, 1..16.
- `BASE_ADDR`, default 32'h0300_0000: start of window 0, aligned to the window size.
- `WINDOW_BITS`, default 16: each window spans 2^WINDOW_BITS bytes. Window i = BASE_ADDR + i·2^WINDOW_BITS.
- `TIMEOUT_CYCLES`, default 255: maximum cycles in ACCESS before abort, 1..65535.
- `ERR_DATA`, default 32'hBAD0_BAD0: read data returned on error.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mst_valid` in 1: master request. The master holds it and all request fields stable until `mst_ready`.
- `mst_ready` out 1: single-cycle completion pulse.
- `mst_wstrb` in 4: byte write enables. 0 means read.
- `mst_addr` in 32: byte address.
- `mst_wdata` in 32: write data.
- `mst_rdata` out 32: read data, valid while `mst_ready` is 1.
- `slv_valid` out NUM_SLAVES: one-hot request.
- `slv_ready` in NUM_SLAVES: per-slave completion.
- `slv_wstrb` out 4, `slv_addr` out 32, `slv_wdata` out 32: registered copies of the request, shared by all slaves.
- `slv_rdata` in 32·NUM_SLAVES: slave i occupies bits [32i+31:32i].
- `err_clr` in 1: clears `err_flag`/`irq_err`.
- `err_flag` out 1: sticky error flag.
- `irq_err` out 1: equal to `err_flag`. Intended for CPU irq line 5..7.
- `err_addr` out 32: address of the most recent error.
- `err_timeout` out 1: most recent error cause. 1 = timeout, 0 = unmapped.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE with `mst_valid`=1:
  - Register addr, wdata, wstrb and the decoded index.
  - Hit → ACCESS.
  - Miss (addr < BASE_ADDR, or index ≥ NUM_SLAVES) → RESP with error.
- ACCESS:
  - `slv_valid[sel]`=1; all other bits 0.
  - `slv_ready[sel]`=1 → capture `slv_rdata[sel]` → RESP. Ready from non-selected slaves is ignored.
- RESP:
  - `mst_ready`=1 for exactly one cycle, then IDLE. `slv_valid`=0.
  - `mst_rdata` holds the captured data, or ERR_DATA on error.
- Error in RESP:
  - Set `err_flag`; load `err_addr` and `err_timeout`.
  - Error and `err_clr` in the same cycle: the flag stays set, so the new error wins.
- Writes to error windows are dropped; the master still completes normally.
- Decode uses unsigned offset = addr − BASE_ADDR; index = offset >> WINDOW_BITS. Offset wrap-around (addr < BASE_ADDR) counts as a miss.

## Timing
- Reset values: every output 0, except `mst_rdata`=0 and `slv_addr`=0. State = IDLE. Timeout counter = 0.
- Reset asserted mid-transaction: all outputs go to 0 immediately and the transaction is lost. The master must be reset too.
- Hit latency: `mst_valid` seen at cycle 0 → `slv_valid` at cycle 1 → `mst_ready` at cycle k+1, where k is the first cycle with `slv_ready[sel]`. Minimum is 2 cycles.
- Miss latency: `mst_ready` at cycle 1.
- Back-to-back: IDLE is re-entered after RESP, so the next request is accepted at cycle k+2 at the earliest.

## Configuration
- `IOMEM_ROUTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When the counter reaches TIMEOUT_CYCLES with `slv_ready[sel]`=0: drop `slv_valid` → RESP with error, `err_timeout`=1.
  - `slv_ready` in the same cycle as expiry wins; the transaction is a normal hit.
- Undefined: no counter. ACCESS waits indefinitely and `err_timeout` is tied to 0.

## Structure
- Package `iomem_router_pkg`: state enum, ERR_DATA default, and the counter width constant (16).
- Sub-module `iomem_router_decode`: combinational addr → {hit, index}, parametrised by BASE_ADDR, WINDOW_BITS and NUM_SLAVES.

## Test plan
- Read hit: addr 0x0301_0004, slave 1 asserts ready 3 cycles after `slv_valid` with rdata 0x1234_5678 → `mst_ready` pulses once with 0x1234_5678; `slv_wstrb`=0.
- Write hit: addr 0x0300_0000, wstrb 4'b0011, wdata 0xA5A5_5A5A, slave 0 ready immediately → `mst_ready` at cycle 2; `slv_wdata`/`slv_wstrb` match.
- Unmapped: addr 0x0304_0000 with NUM_SLAVES=4 → `mst_ready` at cycle 1, rdata 0xBAD0_BAD0, `irq_err`=1, `err_addr`=0x0304_0000, `err_timeout`=0. `err_clr` → `irq_err`=0.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never ready → `slv_valid` drops, `mst_ready` with ERR_DATA, `err_timeout`=1. Repeat with ready on the expiry cycle → normal data, no error.
- Reset mid-ACCESS: deassert `resetn` while `slv_valid`=1 → all outputs 0 asynchronously. After release, a new read completes normally.

Source files
------------

// File: rtl/iomem_router_pkg.sv
// iomem_router_pkg: shared types and constants for the iomem bus router.
// Holds the FSM state type, the default error word and counter widths.
package iomem_router_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hBAD0_BAD0;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 4;

endpackage

// File: rtl/iomem_router_decode.sv
// iomem_router_decode: maps a byte address onto one of N equal windows.
// Addresses below the base wrap the offset and are reported as misses.
import iomem_router_pkg::*;

module iomem_router_decode #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int unsigned WINDOW_BITS = 16
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_index
);

  logic [31:0] w_off;
  logic [31:0] w_idx;

  assign w_off   = i_addr - BASE_ADDR;
  assign w_idx   = w_off >> WINDOW_BITS;
  assign o_hit   = (i_addr >= BASE_ADDR) &&
                   (w_idx < NUM_SLAVES);
  assign o_index = w_idx[IDX_W-1:0];

endmodule

// File: rtl/iomem_bus_router.sv
// iomem_bus_router: one-at-a-time router from the iomem port to N slaves.
// Define IOMEM_ROUTER_TIMEOUT_EN to abort accesses that never complete.
import iomem_router_pkg::*;

module iomem_bus_router #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter int unsigned WINDOW_BITS    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       mst_valid,
  output logic                       mst_ready,
  input  logic [3:0]                 mst_wstrb,
  input  logic [31:0]                mst_addr,
  input  logic [31:0]                mst_wdata,
  output logic [31:0]                mst_rdata,
  output logic [NUM_SLAVES-1:0]      slv_valid,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  output logic [3:0]                 slv_wstrb,
  output logic [31:0]                slv_addr,
  output logic [31:0]                slv_wdata,
  input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
  input  logic                       err_clr,
  output logic                       err_flag,
  output logic                       irq_err,
  output logic [31:0]                err_addr,
  output logic                       err_timeout
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 ||
      TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("iomem_bus_router: bad parameters");
  end

  state_t                r_state;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [NUM_SLAVES-1:0] r_onehot;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_eflag;
  logic [31:0]           r_eaddr;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_index;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [31:0]           w_sel_rdata;
  logic                  w_sel_ready;

  iomem_router_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .WINDOW_BITS (WINDOW_BITS)
  ) u_decode (
    .i_addr  (mst_addr),
    .o_hit   (w_hit),
    .o_index (w_index)
  );

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      w_onehot[i] = w_hit &&
                    (w_index == IDX_W'(i));
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (r_onehot[i])
        w_sel_rdata = w_sel_rdata |
                      slv_rdata[32*i +: 32];
  end

  // ready from slaves other than the selected one never reaches the FSM
  assign w_sel_ready = |(slv_ready & r_onehot);

`ifdef IOMEM_ROUTER_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_to;
  logic             r_etimeout;
  logic             w_expire;

  assign w_expire = (r_cnt ==
                     CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_onehot <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
      r_cnt    <= '0;
      r_to     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mst_valid) begin
            r_addr   <= mst_addr;
            r_wdata  <= mst_wdata;
            r_wstrb  <= mst_wstrb;
            r_onehot <= w_onehot;
            if (w_hit) begin
              r_state <= S_ACCESS;
              r_err   <= 1'b0;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
              r_cnt   <= '0;
              r_to    <= 1'b0;
`endif
            end else begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
              r_rdata <= ERR_DATA;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
              r_to    <= 1'b0;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            r_rdata <= w_sel_rdata;
            r_state <= S_RESP;
          end
`ifdef IOMEM_ROUTER_TIMEOUT_EN
          else if (w_expire) begin
            r_rdata <= ERR_DATA;
            r_err   <= 1'b1;
            r_to    <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_eflag <= 1'b0;
      r_eaddr <= '0;
    end else if (r_state == S_RESP && r_err) begin
      r_eflag <= 1'b1;
      r_eaddr <= r_addr;
    end else if (err_clr) begin
      r_eflag <= 1'b0;
    end
  end

`ifdef IOMEM_ROUTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_etimeout <= 1'b0;
    else if (r_state == S_RESP && r_err)
      r_etimeout <= r_to;
  end

  assign err_timeout = r_etimeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign mst_ready = (r_state == S_RESP);
  assign mst_rdata = r_rdata;
  assign slv_valid = (r_state == S_ACCESS) ?
                     r_onehot : '0;
  assign slv_addr  = r_addr;
  assign slv_wdata = r_wdata;
  assign slv_wstrb = r_wstrb;
  assign err_flag  = r_eflag;
  assign irq_err   = r_eflag;
  assign err_addr  = r_eaddr;

endmodule

// File: tb/tb_iomem_bus_router.sv
// tb_iomem_bus_router: directed and randomized checks of the iomem router.
// Timeout scenarios follow IOMEM_ROUTER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_iomem_bus_router;

  localparam int NS = 4;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int WB = 16;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hBAD0_BAD0;

  logic clk = 0;
  logic resetn = 0;
  logic mst_valid = 0;
  logic mst_ready;
  logic [3:0] mst_wstrb = 0;
  logic [31:0] mst_addr = 0;
  logic [31:0] mst_wdata = 0;
  logic [31:0] mst_rdata;
  logic [NS-1:0] slv_valid;
  logic [NS-1:0] slv_ready = 0;
  logic [3:0] slv_wstrb;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [32*NS-1:0] slv_rdata;
  logic err_clr = 0;
  logic err_flag;
  logic irq_err;
  logic [31:0] err_addr;
  logic err_timeout;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [NS];
  int lat = 0;
  bit noise = 0;
  int scnt = 0;

  typedef struct {
    logic [31:0] rdata, addr, wdata, eaddr;
    logic [3:0] wstrb;
    logic [NS-1:0] vmask;
    int cyc, vcyc;
    bit multi, again, flag, irq, eto;
  } obs_t;

  iomem_bus_router #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE),
    .WINDOW_BITS(WB), .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mst_valid(mst_valid), .mst_ready(mst_ready),
    .mst_wstrb(mst_wstrb), .mst_addr(mst_addr),
    .mst_wdata(mst_wdata), .mst_rdata(mst_rdata),
    .slv_valid(slv_valid), .slv_ready(slv_ready),
    .slv_wstrb(slv_wstrb), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .err_clr(err_clr), .err_flag(err_flag),
    .irq_err(irq_err), .err_addr(err_addr),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_rd
    assign slv_rdata[32*g +: 32] = mem[g];
  end

  // slave model: answers lat cycles after request (lat<0: never)
  always @(negedge clk) begin
    logic [NS-1:0] nz;
    nz = noise ? NS'($urandom) : '0;
    if (slv_valid != 0) begin
      slv_ready = ((lat >= 0 && scnt == lat) ? slv_valid : '0)
                | (nz & ~slv_valid);
      scnt++;
    end else begin
      slv_ready = nz;
      scnt = 0;
    end
  end

  function automatic bit m_hit(input logic [31:0] a, output int idx);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    idx = 0;
    if (off < 0) return 0;
    idx = int'(off / (longint'(1) << WB));
    return idx < NS;
  endfunction

  function automatic int m_cyc(input bit hit, input int l);
    if (!hit) return 1;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
    if (l < 0 || l >= TO) return TO + 1;
`endif
    return l + 2;
  endfunction

  task automatic do_txn(input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output obs_t o);
    o.rdata = '0; o.addr = '0; o.wdata = '0; o.wstrb = '0;
    o.vmask = '0; o.cyc = -1; o.vcyc = 0; o.multi = 0;
    @(negedge clk);
    mst_valid = 1; mst_addr = a; mst_wstrb = s; mst_wdata = d;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (slv_valid != 0) begin
        o.vcyc++;
        o.vmask |= slv_valid;
        if (!$onehot(slv_valid)) o.multi = 1;
        o.addr = slv_addr; o.wdata = slv_wdata; o.wstrb = slv_wstrb;
      end
      if (mst_ready) begin
        o.cyc = c; o.rdata = mst_rdata;
        break;
      end
    end
    mst_valid = 0;
    @(negedge clk);
    o.again = mst_ready; o.flag = err_flag; o.irq = irq_err;
    o.eaddr = err_addr; o.eto = err_timeout;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic test_reset();
    logic [135:0] outs;
    resetn = 0;
    repeat (3) @(negedge clk);
    outs = {mst_ready, mst_rdata, slv_valid, slv_wstrb, slv_addr,
            slv_wdata, err_flag, irq_err, err_addr, err_timeout};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    resetn = 1;
    @(negedge clk);
    checks++;
    if (mst_ready !== 1'b0 || slv_valid !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got rdy=%b v=%b exp 0", mst_ready, slv_valid);
    end
  endtask

  task automatic test_read_hit();
    obs_t o;
    mem[1] = 32'h1234_5678; lat = 3;
    do_txn(32'h0301_0004, 4'b0000, 32'h0, o);
    checks++;
    if (o.cyc !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", o.cyc); end
    checks++;
    if (o.rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", o.rdata); end
    checks++;
    if (o.vmask !== 4'b0010 || o.multi || o.vcyc !== 4) begin
      failures++; $display("FAIL rd_select got=%b/%0d exp=0010/4", o.vmask, o.vcyc);
    end
    checks++;
    if (o.wstrb !== 4'h0 || o.addr !== 32'h0301_0004 || o.again !== 1'b0) begin
      failures++; $display("FAIL rd_fields got strb=%h addr=%h again=%b", o.wstrb, o.addr, o.again);
    end
  endtask

  task automatic test_write_hit();
    obs_t o;
    mem[0] = 32'h0BAD_F00D; lat = 0;
    do_txn(32'h0300_0000, 4'b0011, 32'hA5A5_5A5A, o);
    checks++;
    if (o.cyc !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", o.cyc); end
    checks++;
    if (o.wdata !== 32'hA5A5_5A5A || o.wstrb !== 4'b0011) begin
      failures++; $display("FAIL wr_fields got=%h/%b exp=a5a55a5a/0011", o.wdata, o.wstrb);
    end
    checks++;
    if (o.vmask !== 4'b0001 || o.flag !== 1'b0) begin
      failures++; $display("FAIL wr_select got=%b flag=%b exp=0001/0", o.vmask, o.flag);
    end
  endtask

  task automatic test_unmapped();
    obs_t o;
    do_txn(32'h0304_0000, 4'b0000, 32'h0, o);
    checks++;
    if (o.cyc !== 1 || o.rdata !== ERRD || o.vmask !== '0) begin
      failures++; $display("FAIL miss_resp got cyc=%0d data=%h v=%b", o.cyc, o.rdata, o.vmask);
    end
    checks++;
    if (o.irq !== 1'b1 || o.eaddr !== 32'h0304_0000 || o.eto !== 1'b0) begin
      failures++; $display("FAIL miss_err got irq=%b addr=%h to=%b", o.irq, o.eaddr, o.eto);
    end
    pulse_clr();
    checks++;
    if (irq_err !== 1'b0 || err_flag !== 1'b0) begin
      failures++; $display("FAIL err_clr got irq=%b exp=0", irq_err);
    end
    do_txn(32'h02FF_FFFC, 4'b1111, 32'h1111_2222, o);
    checks++;
    if (o.cyc !== 1 || o.vmask !== '0 || o.eaddr !== 32'h02FF_FFFC || o.flag !== 1'b1) begin
      failures++; $display("FAIL below_base got cyc=%0d v=%b addr=%h", o.cyc, o.vmask, o.eaddr);
    end
    pulse_clr();
  endtask

  task automatic test_clr_collision();
    obs_t o;
    err_clr = 1;
    do_txn(32'h0000_1000, 4'b0000, 32'h0, o);
    checks++;
    if (o.flag !== 1'b1 || o.eaddr !== 32'h0000_1000) begin
      failures++; $display("FAIL clr_collision got flag=%b addr=%h exp=1", o.flag, o.eaddr);
    end
    @(negedge clk);
    err_clr = 0;
    checks++;
    if (err_flag !== 1'b0) begin
      failures++; $display("FAIL clr_after got=%b exp=0", err_flag);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    mem[2] = 32'hCAFE_0002;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
    lat = -1;
    do_txn(32'h0302_0010, 4'b0000, 32'h0, o);
    checks++;
    if (o.cyc !== TO + 1 || o.vcyc !== TO || o.rdata !== ERRD) begin
      failures++; $display("FAIL to_abort got cyc=%0d v=%0d data=%h", o.cyc, o.vcyc, o.rdata);
    end
    checks++;
    if (o.flag !== 1'b1 || o.eto !== 1'b1 || o.eaddr !== 32'h0302_0010) begin
      failures++; $display("FAIL to_err got flag=%b to=%b addr=%h", o.flag, o.eto, o.eaddr);
    end
    pulse_clr();
    lat = TO - 1;
    do_txn(32'h0302_0014, 4'b0000, 32'h0, o);
    checks++;
    if (o.cyc !== TO + 1 || o.rdata !== 32'hCAFE_0002 || o.flag !== 1'b0) begin
      failures++; $display("FAIL to_edge got cyc=%0d data=%h flag=%b", o.cyc, o.rdata, o.flag);
    end
`else
    lat = 20;
    do_txn(32'h0302_0010, 4'b0000, 32'h0, o);
    checks++;
    if (o.cyc !== 22 || o.rdata !== 32'hCAFE_0002 || o.flag !== 1'b0 || o.eto !== 1'b0) begin
      failures++; $display("FAIL no_timeout got cyc=%0d data=%h flag=%b", o.cyc, o.rdata, o.flag);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int gap;
    mem[0] = 32'h0000_AAAA; mem[3] = 32'h0000_BBBB; lat = 0;
    @(negedge clk);
    mst_valid = 1; mst_addr = 32'h0300_0100; mst_wstrb = 0;
    for (int c = 0; c < 20 && !mst_ready; c++) @(negedge clk);
    mst_addr = 32'h0303_0200;
    gap = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mst_ready) begin gap = c; break; end
    end
    checks++;
    if (gap !== 3 || mst_rdata !== 32'h0000_BBBB) begin
      failures++; $display("FAIL b2b got gap=%0d data=%h exp=3/0000bbbb", gap, mst_rdata);
    end
    mst_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    bit eflag;
    logic [31:0] eaddr, a, d;
    logic [3:0] s;
    int idx, kind, ec;
    bit hit;
    pulse_clr();
    eflag = 0; eaddr = '0;
    noise = 1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NS; i++) mem[i] = $urandom;
      kind = $urandom_range(0, 5);
      if (kind < 3)
        a = BASE + ($urandom_range(0, NS - 1) << WB) + ($urandom & 32'h0000_FFFC);
      else if (kind == 3)
        a = BASE + (NS << WB) + ($urandom & 32'h00FF_FFFC);
      else if (kind == 4)
        a = $urandom_range(0, 32'h02FF_FFFF);
      else
        a = 32'hFFFF_FFFC;
      s = 4'($urandom); d = $urandom;
      lat = $urandom_range(0, 4);
      hit = m_hit(a, idx);
      ec = m_cyc(hit, lat);
      do_txn(a, s, d, o);
      if (!hit) begin eflag = 1; eaddr = a; end
      checks++;
      if (o.cyc !== ec || o.again !== 1'b0) begin
        failures++; $display("FAIL rnd_latency a=%h got=%0d exp=%0d", a, o.cyc, ec);
      end
      checks++;
      if (o.rdata !== (hit ? mem[idx] : ERRD)) begin
        failures++; $display("FAIL rnd_data a=%h got=%h exp=%h", a, o.rdata, hit ? mem[idx] : ERRD);
      end
      checks++;
      if (o.vmask !== (hit ? NS'(1) << idx : '0) || o.multi) begin
        failures++; $display("FAIL rnd_select a=%h got=%b", a, o.vmask);
      end
      if (hit) begin
        checks++;
        if (o.addr !== a || o.wdata !== d || o.wstrb !== s) begin
          failures++; $display("FAIL rnd_fields a=%h got=%h/%h/%h", a, o.addr, o.wdata, o.wstrb);
        end
      end
      checks++;
      if (o.flag !== eflag || (eflag && o.eaddr !== eaddr) || o.eto !== 1'b0) begin
        failures++; $display("FAIL rnd_err a=%h got=%b/%h exp=%b/%h", a, o.flag, o.eaddr, eflag, eaddr);
      end
    end
    noise = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [135:0] outs;
    do_txn(32'h0305_0000, 4'b0000, 32'h0, o);
    lat = -1;
    @(negedge clk);
    mst_valid = 1; mst_addr = 32'h0301_0000; mst_wstrb = 4'hF; mst_wdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    checks++;
    if (slv_valid !== 4'b0010) begin
      failures++; $display("FAIL mid_access got=%b exp=0010", slv_valid);
    end
    #2 resetn = 0;
    #1;
    outs = {mst_ready, mst_rdata, slv_valid, slv_wstrb, slv_addr,
            slv_wdata, err_flag, irq_err, err_addr, err_timeout};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", outs);
    end
    mst_valid = 0;
    @(negedge clk);
    resetn = 1;
    mem[1] = 32'h7777_8888; lat = 1;
    do_txn(32'h0301_0008, 4'b0000, 32'h0, o);
    checks++;
    if (o.cyc !== 3 || o.rdata !== 32'h7777_8888 || o.flag !== 1'b0) begin
      failures++; $display("FAIL after_reset got cyc=%0d data=%h flag=%b", o.cyc, o.rdata, o.flag);
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) mem[i] = '0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_unmapped();
    test_clr_collision();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
